multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control unit for the multicycle ARMv4 core. Sequences instruction fetch, decode, execute, memory and writeback over several cycles. Decodes the ALU command and owns the NZCV flag register and the condition check. Drives every enable and mux select of the shared datapath: one memory port, one ALU, register file, PC and IR.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; 0 = reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S or L
- Rd  in  4  Instr[15:12]
- Cond  in  4  Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables
- AdrSrc, ALUSrcA  out  1 each  mux selects
- ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each

## Operation
- Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- State transitions:
  - FETCH -> DECODE.
  - DECODE: Op=00 and I=0 -> EXECUTER; Op=00 and I=1 -> EXECUTEI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH (no-op).
  - MEMADR: L=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH; MEMWR -> FETCH.
  - EXECUTER/EXECUTEI -> ALUWB -> FETCH; BRANCH -> FETCH.
- Per-state raw controls (any control not listed is 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR and EXECUTEI: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - ALUOp=1 in EXECUTER and EXECUTEI only.
- ALU decode, active when ALUOp=1, otherwise ALUControl=00 and FlagW=00:
  - cmd 0100 ADD -> 00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11; 1010 CMP -> 01 with NoWrite=1; any other cmd -> 00.
  - FlagW[1] (NZ) = S.
  - FlagW[0] (CV) = S & (ADD|SUB|CMP).
- ImmSrc = Op. RegSrc = {Op==01, Op==10}.
- Condition check on the registered Flags, covering EQ..LE per ARMv4:
  - 1110 (AL) -> 1.
  - 1111 -> 0; the instruction executes as a no-op.
- CondEx is evaluated in DECODE and captured into condex_q on the DECODE->next edge. All later gating uses condex_q.
- Flags register:
  - Flags[3:2] <= ALUFlags[3:2] on the edge ending EXECUTER/EXECUTEI when FlagW[1] & condex_q.
  - Flags[1:0] follow the same rule with FlagW[0].
- Output gating:
  - PCS = Branch | (RegW & Rd==15).
  - PCWrite = NextPC | (PCS & condex_q).
  - RegWrite = RegW & condex_q & ~NoWrite.
  - MemWrite = MemW & condex_q.
  - NoWrite is decoded from the instruction held in IR, so it is stable through ALUWB.

## Timing
- reset=0 sampled at a rising edge: state=FETCH, Flags=0000, condex_q=0.
- While reset=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Selects show their FETCH values.
- Reset asserted mid-instruction aborts the instruction. No partial write occurs after the edge that samples reset=0.
- Latency in cycles, measured FETCH to next FETCH:
  - data-processing 4, LDR 5, STR 4, B 3, Op=11 2.
- Flags written by an instruction are visible to the Cond of the next instruction, whose DECODE comes at least 2 cycles later.
- Outputs are combinational from state, IR fields and condex_q only. ALUFlags affects only register inputs, so there is no combinational path from ALUFlags to any output.

## Configuration
- MULTICYCLE_CTRL_CMP_EN
  - Defined: cmd 1010 decodes as CMP, with ALUControl=01, NoWrite=1 and CV flags writable.
  - Undefined: cmd 1010 falls into the "other" group, with ALUControl=00, NoWrite=0 and FlagW[0]=0.

## Structure
- Package multicycle_ctrl_pkg holds:
  - state enum (4-bit);
  - Op codes (DP=00, MEM=01, BR=10);
  - cmd constants ADD/SUB/AND/ORR/CMP;
  - ALUControl encodings;
  - Cond codes.
- One sub-module, multicycle_main_fsm: state register, next-state logic and raw per-state controls.
- The top level holds the ALU decoder, condition check, Flags register, condex_q and output gating.

## Test plan
- Reset: hold reset=0 for 2 cycles in the middle of an LDR -> all four enables stay 0 and Flags=0000. After release, IRWrite=1 and PCWrite=1 on the first cycle.
- ADDS, Cond=1110, Rd=3, ALUFlags=0110 in EXECUTER -> ALUControl=00; RegWrite=1 in ALUWB; Flags=0110; exactly 4 cycles.
- BEQ after the case above (Z=1) -> PCWrite=1 in BRANCH, ALUSrcB=01, 3 cycles. With Flags=0000 -> PCWrite=0 in BRANCH.
- LDR, Rd=15, Cond=AL -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, with AdrSrc=1 in MEMRD. In MEMWB: ResultSrc=01, RegWrite=1, PCWrite=1.
- STR, Cond=0001, Flags Z=1 -> MemWrite=0 in MEMWR and 4 cycles total.
- CMP, S=1, ALUFlags=1000:
  - With MULTICYCLE_CTRL_CMP_EN -> RegWrite=0 in ALUWB; Flags become 1000 (N and Z from ALUFlags; C and V rewritten to 0).
  - Without it -> RegWrite=1; ALUControl=00; Flags[3:2]=10 written, Flags[1:0] unchanged.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARMv4 control unit.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // flags is {N,Z,C,V}; the 1111 encoding never executes
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_check = z;
            COND_NE: cond_check = ~z;
            COND_CS: cond_check = c;
            COND_CC: cond_check = ~c;
            COND_MI: cond_check = n;
            COND_PL: cond_check = ~n;
            COND_VS: cond_check = v;
            COND_VC: cond_check = ~v;
            COND_HI: cond_check = c & ~z;
            COND_LS: cond_check = ~(c & ~z);
            COND_GE: cond_check = (n == v);
            COND_LT: cond_check = (n != v);
            COND_GT: cond_check = ~z & (n == v);
            COND_LE: cond_check = ~(~z & (n == v));
            COND_AL: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main sequencing FSM: state register, next-state logic and raw per-state controls.
// While reset is low the controls decode as FETCH so the datapath selects stay defined.
import multicycle_ctrl_pkg::*;

module multicycle_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       imm,
    input  logic       load,
    output state_t     state,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       alu_op
);

    state_t state_q, state_d, cur;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        cur        = reset ? state_q : S_FETCH;
        state_d    = S_FETCH;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (cur)
            S_FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    OP_DP:   state_d = imm ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = load ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARMv4 control unit: ALU decode, NZCV flags, condition check and write gating.
// Define MULTICYCLE_CTRL_CMP_EN to decode cmd 1010 as CMP.
import multicycle_ctrl_pkg::*;

module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    state_t     state;
    logic       ir_write, next_pc, reg_w, mem_w, branch, alu_op;
    logic [1:0] flag_w;
    logic [3:0] flags;
    logic       condex, condex_q, no_write, pcs;

    multicycle_main_fsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .op         (Op),
        .imm        (Funct[5]),
        .load       (Funct[0]),
        .state      (state),
        .ir_write   (ir_write),
        .next_pc    (next_pc),
        .adr_src    (AdrSrc),
        .alu_src_a  (ALUSrcA),
        .alu_src_b  (ALUSrcB),
        .result_src (ResultSrc),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .alu_op     (alu_op)
    );

    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
`ifdef MULTICYCLE_CTRL_CMP_EN
                CMD_CMP: ALUControl = ALU_SUB;
`endif
                default: ALUControl = ALU_ADD;
            endcase
            flag_w[1] = Funct[0];
`ifdef MULTICYCLE_CTRL_CMP_EN
            flag_w[0] = Funct[0] & ((Funct[4:1] == CMD_ADD) | (Funct[4:1] == CMD_SUB) |
                                    (Funct[4:1] == CMD_CMP));
`else
            flag_w[0] = Funct[0] & ((Funct[4:1] == CMD_ADD) | (Funct[4:1] == CMD_SUB));
`endif
        end
    end

    // Decoded from the held instruction, not gated by alu_op, so it still holds in ALUWB
`ifdef MULTICYCLE_CTRL_CMP_EN
    assign no_write = (Op == OP_DP) && (Funct[4:1] == CMD_CMP);
`else
    assign no_write = 1'b0;
`endif

    assign condex = cond_check(Cond, flags);

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags    <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            if (state == S_DECODE) condex_q <= condex;
            if (flag_w[1] & condex_q) flags[3:2] <= ALUFlags[3:2];
            if (flag_w[0] & condex_q) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign pcs      = branch | (reg_w & (Rd == 4'd15));
    assign PCWrite  = reset & (next_pc | (pcs & condex_q));
    assign IRWrite  = reset & ir_write;
    assign RegWrite = reset & reg_w & condex_q & ~no_write;
    assign MemWrite = reset & mem_w & condex_q;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a linear walk through reset, DP, branch, load/store and CMP cases.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALUFlags parked at 1111 outside EXECUTE so a stray flag write shows up
    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = 4'hF;
        #1;
    endtask

    task automatic set_alu_flags(input logic [3:0] a);
        ALUFlags = a;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_instr(4'b1110, 2'b00, 6'b000000, 4'd0);

        // power-on reset, sampled over two edges
        tick(); tick();
        chk("rst_enables", {4'b0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h00);
        chk("rst_selects", {3'b0, ALUSrcA, ALUSrcB, ResultSrc}, {3'b0, 1'b1, 2'b10, 2'b10});
        chk("rst_flags", {4'b0, dut.flags}, 8'h00);
        reset = 1'b1; #1;
        chk("rel_fetch", {6'b0, IRWrite, PCWrite}, 8'h03);

        // ADDS AL Rd=3
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd3);
        tick();
        chk("adds_decode", {4'b0, IRWrite, PCWrite, ALUSrcB}, {4'b0, 1'b0, 1'b0, 2'b10});
        tick(); set_alu_flags(4'b0110);
        chk("adds_exec", {3'b0, ALUSrcA, ALUSrcB, ALUControl}, {3'b0, 1'b0, 2'b00, 2'b00});
        tick();
        chk("adds_aluwb", {5'b0, RegWrite, PCWrite, IRWrite}, 8'h04);
        chk("adds_flags", {4'b0, dut.flags}, 8'h06);
        tick();
        chk("adds_lat4", {7'b0, IRWrite}, 8'h01);

        // BEQ with Z=1
        set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
        tick(); tick();
        chk("beq_taken", {3'b0, PCWrite, ALUSrcB, ResultSrc}, {3'b0, 1'b1, 2'b01, 2'b10});
        tick();
        chk("beq_lat3", {7'b0, IRWrite}, 8'h01);

        // LDR AL Rd=15
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd15);
        tick(); tick();
        chk("ldr_memadr", {4'b0, ALUSrcB, 1'b0, AdrSrc}, {4'b0, 2'b01, 1'b0, 1'b0});
        chk("ldr_srcs", {4'b0, ImmSrc, RegSrc}, {4'b0, 2'b01, 2'b10});
        tick();
        chk("ldr_memrd", {5'b0, AdrSrc, RegWrite, PCWrite}, 8'h04);
        tick();
        chk("ldr_memwb", {4'b0, ResultSrc, RegWrite, PCWrite}, {4'b0, 2'b01, 1'b1, 1'b1});
        tick();
        chk("ldr_lat5", {7'b0, IRWrite}, 8'h01);

        // STRNE with Z=1 squashed, then STR AL
        set_instr(4'b0001, 2'b01, 6'b011000, 4'd2);
        tick(); tick(); tick();
        chk("strne_memwr", {6'b0, AdrSrc, MemWrite}, 8'h02);
        tick();
        chk("strne_lat4", {7'b0, IRWrite}, 8'h01);
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd2);
        tick(); tick(); tick();
        chk("str_memwr", {6'b0, AdrSrc, MemWrite}, 8'h03);
        tick();

        // CMP S=1, ALUFlags=1000
        set_instr(4'b1110, 2'b00, 6'b010101, 4'd0);
        tick(); tick(); set_alu_flags(4'b1000);
`ifdef MULTICYCLE_CTRL_CMP_EN
        chk("cmp_aluctl", {6'b0, ALUControl}, 8'h01);
        tick();
        chk("cmp_regwrite", {7'b0, RegWrite}, 8'h00);
        chk("cmp_flags", {4'b0, dut.flags}, 8'h08);
`else
        chk("cmp_aluctl", {6'b0, ALUControl}, 8'h00);
        tick();
        chk("cmp_regwrite", {7'b0, RegWrite}, 8'h01);
        chk("cmp_flags", {4'b0, dut.flags}, 8'h0A);
`endif
        tick();

        // ADDS AL with ALUFlags=0000 clears all flags
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd1);
        tick(); tick(); set_alu_flags(4'b0000);
        tick();
        chk("clr_flags", {4'b0, dut.flags}, 8'h00);
        tick();

        // BEQ with Z=0 not taken
        set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
        tick(); tick();
        chk("beq_nottaken", {7'b0, PCWrite}, 8'h00);
        tick();

        // Op=11 no-op: two cycles
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd0);
        tick();
        chk("nop_decode", {7'b0, IRWrite}, 8'h00);
        tick();
        chk("nop_lat2", {7'b0, IRWrite}, 8'h01);

        // SUB immediate, no S, Rd=15: PC write, flags untouched
        set_instr(4'b1110, 2'b00, 6'b100100, 4'd15);
        tick(); tick(); set_alu_flags(4'b1111);
        chk("subi_exec", {3'b0, ALUSrcA, ALUSrcB, ALUControl}, {3'b0, 1'b0, 2'b01, 2'b01});
        tick();
        chk("subi_aluwb", {6'b0, RegWrite, PCWrite}, 8'h03);
        chk("subi_flags", {4'b0, dut.flags}, 8'h00);
        tick();

        // ADDSLT with N==V: squashed, no register or flag write
        set_instr(4'b1011, 2'b00, 6'b001001, 4'd4);
        tick(); tick(); set_alu_flags(4'b1111);
        tick();
        chk("addslt_aluwb", {7'b0, RegWrite}, 8'h00);
        chk("addslt_flags", {4'b0, dut.flags}, 8'h00);
        tick();

        // ADDSGE with N==V: executes, flags become 0101
        set_instr(4'b1010, 2'b00, 6'b001001, 4'd4);
        tick(); tick(); set_alu_flags(4'b0101);
        tick();
        chk("addsge_aluwb", {7'b0, RegWrite}, 8'h01);
        chk("addsge_flags", {4'b0, dut.flags}, 8'h05);
        tick();

        // LDR PC aborted by reset in MEMRD
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd15);
        tick(); tick(); tick();
        reset = 1'b0; #1;
        chk("abort_enables0", {4'b0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h00);
        chk("abort_selects", {2'b0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc},
            {2'b0, 1'b0, 1'b1, 2'b10, 2'b10});
        tick();
        chk("abort_enables1", {4'b0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h00);
        tick();
        chk("abort_enables2", {4'b0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h00);
        chk("abort_flags", {4'b0, dut.flags}, 8'h00);
        reset = 1'b1; #1;
        chk("abort_rel", {6'b0, IRWrite, PCWrite}, 8'h03);
        tick();
        chk("abort_decode", {6'b0, IRWrite, ALUSrcA}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
